// File: rtl/spi_reg_pkg.sv
// Shared definitions for the bridge-link SPI register protocol.
package spi_reg_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // Bit 7 of the address byte selects the direction.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BIT_LO,
    S_BIT_HI,
    S_NEXT,
    S_HOLD,
    S_GAP
  } ctrl_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer: while run_i is high it counts CLK_DIV clk cycles per
// half period and strobes rise_o / fall_o in the last cycle of the low / high
// half. Dropping run_i restarts it at the beginning of a low half.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;
  logic          tick;

  assign tick   = run_i && (div_q == DW'(CLK_DIV - 1));
  assign rise_o = tick && !phase_q;
  assign fall_o = tick && phase_q;

  // Next half-period count and phase.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!run_i) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI Mode 0 master for the bridge-link register protocol: one address byte
// {rw, addr} followed by cmd_len data bytes, MSB first. Write bytes are pulled
// from the host with wr_valid/wr_ready, read bytes are pushed with rd_valid.
// CLK_DIV must be at least 4: the target resynchronises SCK through 3 flops.
module spi_controller
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int CNT_W = 8;

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        bytes_left_q, bytes_left_d;
  logic              rw_q, rw_d;
  logic              is_addr_q, is_addr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              miso_s1_q, miso_s2_q;
  logic              sck_rise, sck_fall;

  // Half-period timer runs only while bits are being clocked.
  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .run_i ((state_q == S_BIT_LO) || (state_q == S_BIT_HI)),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = tx_q[DATA_W-1];
  assign spi_cs_n  = cs_n_q;

  // Two-flop synchroniser for MISO, which is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // Transaction sequencing: next state, shift registers and output strobes.
  always_comb begin
    // NOTE: every _d starts at its hold value (strobes at 0) so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    rw_d         = rw_q;
    is_addr_d    = is_addr_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rd_data_d    = rd_data_q;
    busy_d       = busy_q;
    sck_d        = sck_q;
    cs_n_d       = cs_n_q;
    rd_valid_d   = 1'b0;
    wr_ready_d   = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rw_d         = cmd_rw;
          tx_d         = {cmd_rw, cmd_addr};
          bytes_left_d = cmd_len;
          is_addr_d    = 1'b1;
          bit_cnt_d    = '0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          cs_n_d       = 1'b0;
          state_d      = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_BIT_LO;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_BIT_LO: begin
        if (sck_rise) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_W-3:0], miso_s2_q};
          state_d = S_BIT_HI;
          // Hand a read byte over on its last rising edge, not at the fall.
          if ((bit_cnt_q == 3'd7) && !is_addr_q && (rw_q == RW_READ)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = {rx_q, miso_s2_q};
          end
        end
      end

      S_BIT_HI: begin
        if (sck_fall) begin
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q != 3'd7) begin
            tx_d    = {tx_q[DATA_W-2:0], 1'b0};
            state_d = S_BIT_LO;
          end else begin
            if (!is_addr_q && (bytes_left_q != '0)) begin
              bytes_left_d = bytes_left_q - 1'b1;
            end
            is_addr_d = 1'b0;
            state_d   = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (bytes_left_q == '0) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (rw_q == RW_READ) begin
          tx_d    = '0;
          state_d = S_BIT_LO;
        end else if (wr_valid) begin
          // A write stalls here, SCK low and CS_n low, until data arrives.
          wr_ready_d = 1'b1;
          tx_d       = wr_data;
          state_d    = S_BIT_LO;
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      bytes_left_q <= '0;
      rw_q         <= 1'b0;
      is_addr_q    <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      wr_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sck_q        <= 1'b0;
      cs_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
      rw_q         <= rw_d;
      is_addr_q    <= is_addr_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      wr_ready_q   <= wr_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sck_q        <= sck_d;
      cs_n_q       <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a behavioural SPI register target on the bus, a
// reference register array for expectations, and directed plus random commands.
module tb_spi_controller;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, done;
  logic       spi_sck, spi_mosi, spi_miso, spi_cs_n;

  spi_controller #(
    .CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register contents: tgt_mem is what the bus target holds, ref_mem is what it should hold.
  logic [7:0] tgt_mem [128];
  logic [7:0] ref_mem [128];
  logic [7:0] wdata   [256];

  // Observations gathered from the bus and host ports.
  logic [7:0] mosi_bytes [$];
  logic [7:0] rd_q [$];
  int rise_cnt, done_cnt, wr_cnt, accept_cnt, ready_bad, last_gap, cs_hi_run;
  logic busy_prev, cs_prev;

  // Behavioural SPI Mode 0 register target: samples MOSI on rising SCK, drives MISO
  // on falling SCK, auto-increments the address after every data byte.
  initial begin : target
    int         bitn;
    logic [7:0] sh_in, sh_out;
    logic       t_rd;
    int         t_addr;
    bitn = 0; t_rd = 1'b0; t_addr = 0; sh_in = '0; sh_out = '0;
    spi_miso = 1'b0;
    forever begin
      @(posedge spi_sck or negedge spi_sck or posedge spi_cs_n);
      if (spi_cs_n === 1'b1) begin
        bitn = 0; t_rd = 1'b0; spi_miso = 1'b0;
      end else if (spi_sck === 1'b1) begin
        sh_in = {sh_in[6:0], spi_mosi};
        bitn++;
        rise_cnt++;
        if (bitn % 8 == 0) begin
          mosi_bytes.push_back(sh_in);
          if (bitn == 8) begin
            t_rd = sh_in[7]; t_addr = int'(sh_in[6:0]);
          end else if (!t_rd) begin
            tgt_mem[t_addr] = sh_in; t_addr = (t_addr + 1) % 128;
          end
        end
      end else if (t_rd && bitn >= 8) begin
        if (bitn % 8 == 0) begin
          sh_out = tgt_mem[t_addr]; t_addr = (t_addr + 1) % 128;
        end else begin
          sh_out = {sh_out[6:0], 1'b0};
        end
        spi_miso = sh_out[7];
      end
    end
  end

  // Host-side monitor, sampled on the falling clk edge.
  initial begin : monitor
    busy_prev = 1'b0; cs_prev = 1'b1; cs_hi_run = 0; last_gap = 0; ready_bad = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (wr_ready === 1'b1) wr_cnt++;
      if (rd_valid === 1'b1) rd_q.push_back(rd_data);
      if (busy === 1'b1 && !busy_prev) accept_cnt++;
      if (busy === 1'b1 && cmd_ready === 1'b1) ready_bad++;
      if (spi_cs_n === 1'b0 && cs_prev) last_gap = cs_hi_run;
      cs_hi_run = (spi_cs_n === 1'b1) ? cs_hi_run + 1 : 0;
      busy_prev = (busy === 1'b1);
      cs_prev   = (spi_cs_n === 1'b1);
    end
  end

  task automatic clear_obs();
    rise_cnt = 0; done_cnt = 0; wr_cnt = 0; accept_cnt = 0;
    mosi_bytes.delete(); rd_q.delete();
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check("cmd_ready_timeout", cmd_ready, 1'b1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin @(negedge clk); k++; end
    check("done_count", done_cnt, n);
  endtask

  task automatic issue_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] len);
    wait_ready(500);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rw = $urandom_range(0, 1); cmd_addr = 7'($urandom); cmd_len = 8'($urandom);
  endtask

  task automatic feed_byte(input logic [7:0] d);
    int k = 0;
    wr_valid = 1'b1; wr_data = d;
    do begin @(negedge clk); k++; end while (wr_ready !== 1'b1 && k < 3000);
    check("wr_handshake", wr_ready, 1'b1);
    wr_valid = 1'b0; wr_data = 8'($urandom);
  endtask

  // Wait until the bus is parked before data byte idx, then withhold data and watch it.
  task automatic stall_check(input int idx, input int clks);
    int k = 0;
    int bad = 0;
    while (!(rise_cnt == 8 * (idx + 1) && spi_sck === 1'b0) && k < 3000) begin
      @(negedge clk); k++;
    end
    check("stall_reached", rise_cnt, 8 * (idx + 1));
    repeat (clks) begin
      @(negedge clk);
      if (spi_sck !== 1'b0 || spi_cs_n !== 1'b0) bad++;
    end
    check("stall_bus_parked", bad, 0);
    check("stall_no_edges", rise_cnt, 8 * (idx + 1));
  endtask

  // Full transaction with expectations from the protocol rules and ref_mem.
  task automatic run_cmd(input logic rw, input logic [6:0] addr, input int len,
                         input int stall_idx, input int stall_clks);
    logic [7:0] exp_mosi [$];
    logic [7:0] exp_rd [$];
    clear_obs();
    exp_mosi.push_back({rw, addr});
    for (int i = 0; i < len; i++) begin
      exp_mosi.push_back(rw ? 8'h00 : wdata[i]);
      if (rw) exp_rd.push_back(ref_mem[(int'(addr) + i) % 128]);
    end
    issue_cmd(rw, addr, 8'(len));
    if (!rw) begin
      for (int i = 0; i < len; i++) begin
        if (i == stall_idx) stall_check(i, stall_clks);
        feed_byte(wdata[i]);
      end
    end
    wait_done(1, 6000);
    wait_ready(200);
    check("sck_rises", rise_cnt, 8 * (len + 1));
    check("mosi_byte_count", mosi_bytes.size(), exp_mosi.size());
    foreach (exp_mosi[i]) if (i < mosi_bytes.size()) check("mosi_byte", mosi_bytes[i], exp_mosi[i]);
    if (rw) begin
      check("rd_count", rd_q.size(), len);
      foreach (exp_rd[i]) if (i < rd_q.size()) check("rd_byte", rd_q[i], exp_rd[i]);
    end else begin
      check("wr_ready_count", wr_cnt, len);
      check("rd_none_on_write", rd_q.size(), 0);
      for (int i = 0; i < len; i++) ref_mem[(int'(addr) + i) % 128] = wdata[i];
      for (int i = 0; i < len; i++)
        check("target_reg", tgt_mem[(int'(addr) + i) % 128], ref_mem[(int'(addr) + i) % 128]);
    end
  endtask

  initial begin : stimulus
    logic [7:0] v;
    int k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom); tgt_mem[i] = v; ref_mem[i] = v;
    end
    clear_obs();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sck", spi_sck, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write 0x12, two bytes.
    wdata[0] = 8'hA5; wdata[1] = 8'h3C;
    run_cmd(1'b0, 7'h12, 2, -1, 0);
    check("t1_reg12", tgt_mem[7'h12], 8'hA5);
    check("t1_reg13", tgt_mem[7'h13], 8'h3C);

    // 2: read 0x05, two bytes.
    tgt_mem[5] = 8'h5A; ref_mem[5] = 8'h5A;
    tgt_mem[6] = 8'hC3; ref_mem[6] = 8'hC3;
    run_cmd(1'b1, 7'h05, 2, -1, 0);
    check("t2_first_mosi", (mosi_bytes.size() > 0) ? mosi_bytes[0] : 8'hxx, 8'h85);
    check("t2_rd0", (rd_q.size() > 0) ? rd_q[0] : 8'hxx, 8'h5A);
    check("t2_rd1", (rd_q.size() > 1) ? rd_q[1] : 8'hxx, 8'hC3);

    // 3: write three bytes with a 40 clk stall before data byte 2.
    for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
    run_cmd(1'b0, 7'h50, 3, 2, 40);

    // 4: address-only read of 0x7F.
    run_cmd(1'b1, 7'h7F, 0, -1, 0);
    check("t4_mosi_ff", (mosi_bytes.size() > 0) ? mosi_bytes[0] : 8'hxx, 8'hFF);

    // 5: cmd_valid held through two back-to-back reads.
    clear_obs();
    wait_ready(200);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h30; cmd_len = 8'd1;
    wait_done(2, 6000);
    cmd_valid = 1'b0;
    wait_ready(200);
    check("t5_accepts", accept_cnt, 2);
    check("t5_cs_gap_ge8", last_gap >= 8, 1'b1);
    check("t5_sck_rises", rise_cnt, 32);
    check("t5_rd_count", rd_q.size(), 2);
    foreach (rd_q[i]) check("t5_rd_byte", rd_q[i], ref_mem[7'h30]);

    // 6: reset during bit 4 of data byte 1 of a write, then a clean write.
    clear_obs();
    wdata[0] = 8'($urandom); wdata[1] = 8'($urandom);
    issue_cmd(1'b0, 7'h40, 8'd3);
    feed_byte(wdata[0]);
    feed_byte(wdata[1]);
    k = 0;
    while (rise_cnt < 21 && k < 3000) begin @(negedge clk); k++; end
    check("t6_reached_bit4", rise_cnt, 21);
    #1 rst = 1'b1;
    #1;
    check("t6_cs_n_async", spi_cs_n, 1'b1);
    check("t6_sck_async", spi_sck, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_done", done_cnt, 0);
    check("t6_idle_busy", busy, 1'b0);
    ref_mem[7'h40] = wdata[0];
    check("t6_byte0_landed", tgt_mem[7'h40], ref_mem[7'h40]);
    check("t6_byte1_untouched", tgt_mem[7'h41], ref_mem[7'h41]);
    wdata[0] = 8'h96; wdata[1] = 8'h0F;
    run_cmd(1'b0, 7'h20, 2, -1, 0);

    // Address wrap across 0x7F.
    for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
    run_cmd(1'b0, 7'h7E, 3, -1, 0);
    run_cmd(1'b1, 7'h7E, 3, -1, 0);

    // Random commands.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 5; i++) wdata[i] = 8'($urandom);
      run_cmd(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom_range(0, 4), -1, 0);
    end

    check("ready_low_while_busy", ready_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
